// File: rtl/rx_destuff_ctrl.sv
// Receive-side sequencer for the CAN destuffer: strobes the destuffer at each sample
// point, evaluates its outputs one clock later and tracks frame position to find the end of stuffing.
module rx_destuff_ctrl #(
    parameter int EOF_BITS = 7,
    parameter int MAX_DLC  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sample,
    input  logic       start,
    input  logic       abort,
    input  logic       stuffr,
    input  logic       stferror,
    input  logic       inbit,
    output logic       actvrstf,
    output logic       actvrdct,
    output logic       resetdst,
    output logic       rxbit,
    output logic       bitvalid,
    output logic [6:0] bitpos,
    output logic       ide,
    output logic       rtr,
    output logic [3:0] dlc,
    output logic       busy,
    output logic       frame_done,
    output logic       stferr
);

    localparam int DIRECT_BITS = EOF_BITS + 3;
    localparam int CW = ($clog2(DIRECT_BITS + 1) > 4) ? $clog2(DIRECT_BITS + 1) : 4;
    localparam logic [3:0] DLC_CAP = 4'(MAX_DLC);
    localparam logic [CW-1:0] DCNT_LAST = CW'(DIRECT_BITS - 1);

    typedef enum logic [2:0] {IDLE, STUFF, TAIL, DIRECT, FLUSH} state_t;

    state_t        state, state_nx;
    logic          pend, pend_nx;
    logic [CW-1:0] dcnt, dcnt_nx;
    logic          actvrstf_nx, actvrdct_nx, resetdst_nx, rxbit_nx, bitvalid_nx;
    logic [6:0]    bitpos_nx;
    logic          ide_nx, rtr_nx;
    logic [3:0]    dlc_nx;
    logic          busy_nx, frame_done_nx, stferr_nx;
    logic [3:0]    dlen;
    logic [7:0]    last_idx;
    logic          dlc_slot;

    // Index of the last stuffed bit (end of CRC) from the fields latched so far
    always_comb begin
        dlen     = (dlc > DLC_CAP) ? DLC_CAP : dlc;
        last_idx = (ide ? 8'd53 : 8'd33) + (rtr ? 8'd0 : {1'b0, dlen, 3'b000});
        dlc_slot = (!ide && bitpos >= 7'd15 && bitpos <= 7'd18) ||
                   ( ide && bitpos >= 7'd35 && bitpos <= 7'd38);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        pend_nx       = actvrstf;
        dcnt_nx       = dcnt;
        actvrstf_nx   = 1'b0;
        actvrdct_nx   = 1'b0;
        rxbit_nx      = rxbit;
        bitvalid_nx   = 1'b0;
        bitpos_nx     = bitpos;
        ide_nx        = ide;
        rtr_nx        = rtr;
        dlc_nx        = dlc;
        frame_done_nx = 1'b0;
        stferr_nx     = 1'b0;

        if (state != IDLE && abort) begin
            state_nx = FLUSH;
            pend_nx  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nx  = STUFF;
                        bitpos_nx = '0;
                        ide_nx    = 1'b0;
                        rtr_nx    = 1'b0;
                        dlc_nx    = '0;
                        dcnt_nx   = '0;
                    end
                end
                STUFF, TAIL, DIRECT: begin
                    if (pend) begin
                        if (state == DIRECT) begin
                            bitvalid_nx = 1'b1;
                            rxbit_nx    = inbit;
                            if (dcnt == DCNT_LAST) begin
                                state_nx      = FLUSH;
                                frame_done_nx = 1'b1;
                            end else begin
                                dcnt_nx = dcnt + 1'b1;
                            end
                        end else if (stferror) begin
                            stferr_nx = 1'b1;
                            state_nx  = FLUSH;
                        end else if (!stuffr) begin
                            bitvalid_nx = 1'b1;
                            rxbit_nx    = inbit;
                            if (state == TAIL) begin
                                dcnt_nx  = CW'(1);
                                state_nx = DIRECT;
                            end else begin
                                bitpos_nx = (bitpos == 7'd127) ? bitpos : bitpos + 7'd1;
                                if (bitpos == 7'd12) rtr_nx = inbit;
                                if (bitpos == 7'd13) ide_nx = inbit;
                                if (ide && bitpos == 7'd32) rtr_nx = inbit;
                                if (dlc_slot) dlc_nx = {dlc[2:0], inbit};
                                if ({1'b0, bitpos} == last_idx) state_nx = TAIL;
                            end
                        end
                    end else if (sample) begin
                        actvrstf_nx = 1'b1;
                        actvrdct_nx = (state == DIRECT);
                    end
                end
                FLUSH: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end

        resetdst_nx = !(state_nx == FLUSH || (state == IDLE && state_nx == STUFF));
        busy_nx     = (state_nx != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend       <= 1'b0;
            dcnt       <= '0;
            actvrstf   <= 1'b0;
            actvrdct   <= 1'b0;
            resetdst   <= 1'b1;
            rxbit      <= 1'b0;
            bitvalid   <= 1'b0;
            bitpos     <= '0;
            ide        <= 1'b0;
            rtr        <= 1'b0;
            dlc        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            stferr     <= 1'b0;
        end else begin
            pend       <= pend_nx;
            dcnt       <= dcnt_nx;
            actvrstf   <= actvrstf_nx;
            actvrdct   <= actvrdct_nx;
            resetdst   <= resetdst_nx;
            rxbit      <= rxbit_nx;
            bitvalid   <= bitvalid_nx;
            bitpos     <= bitpos_nx;
            ide        <= ide_nx;
            rtr        <= rtr_nx;
            dlc        <= dlc_nx;
            busy       <= busy_nx;
            frame_done <= frame_done_nx;
            stferr     <= stferr_nx;
        end
    end

endmodule

// File: tb/tb_rx_destuff_ctrl.sv
// Directed, table-driven bench for rx_destuff_ctrl: frames are expanded into per-sample
// records of destuffer responses and expected outputs, then replayed and compared.
module tb_rx_destuff_ctrl;

    logic       clock = 1'b0;
    logic       reset, sample, start, abort, stuffr, stferror, inbit;
    logic       actvrstf, actvrdct, resetdst, rxbit, bitvalid;
    logic [6:0] bitpos;
    logic       ide, rtr;
    logic [3:0] dlc;
    logic       busy, frame_done, stferr;

    rx_destuff_ctrl #(.EOF_BITS(7), .MAX_DLC(8)) dut (
        .clock(clock), .reset(reset), .sample(sample), .start(start), .abort(abort),
        .stuffr(stuffr), .stferror(stferror), .inbit(inbit),
        .actvrstf(actvrstf), .actvrdct(actvrdct), .resetdst(resetdst), .rxbit(rxbit),
        .bitvalid(bitvalid), .bitpos(bitpos), .ide(ide), .rtr(rtr), .dlc(dlc),
        .busy(busy), .frame_done(frame_done), .stferr(stferr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       b, st, se, ab;
        logic       e_bv, e_dct, e_sf, e_done;
        logic [6:0] e_pos;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic last_resetdst, last_busy;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic b, st, se, ab, bv, dct, sf, done, input logic [6:0] pos);
        vec_t v;
        v.b = b; v.st = st; v.se = se; v.ab = ab;
        v.e_bv = bv; v.e_dct = dct; v.e_sf = sf; v.e_done = done; v.e_pos = pos;
        return v;
    endfunction

    // Expand a frame into sample records; stuff_at inserts a stuff bit before index stuff_at
    task automatic build_frame(input logic ext, input logic rtr_b, input logic [3:0] dlc_v,
                               input logic [10:0] id, input int stuff_at, input logic tail_stuff);
        logic bits[$];
        int   d, n;
        vq.delete();
        d = rtr_b ? 0 : 8 * ((dlc_v > 4'd8) ? 8 : int'(dlc_v));
        bits.push_back(1'b0);
        for (int i = 10; i >= 0; i--) bits.push_back(id[i]);
        if (!ext) begin
            bits.push_back(rtr_b); bits.push_back(1'b0); bits.push_back(1'b0);
        end else begin
            bits.push_back(1'b1); bits.push_back(1'b1);
            for (int i = 0; i < 18; i++) bits.push_back((i % 2) == 1);
            bits.push_back(rtr_b); bits.push_back(1'b0); bits.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) bits.push_back(dlc_v[i]);
        for (int i = 0; i < d; i++) bits.push_back(((i / 3) % 2) == 1);
        for (int i = 0; i < 15; i++) bits.push_back((i % 2) == 0);
        n = bits.size();
        for (int k = 0; k < n; k++) begin
            if (k == stuff_at) vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'(k)));
            vq.push_back(mk(bits[k], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'(k + 1)));
        end
        if (tail_stuff) vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'(n)));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'(n)));
        for (int j = 0; j < 9; j++)
            vq.push_back(mk((j != 0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, (j == 8), 7'(n)));
    endtask

    task automatic do_sample(input vec_t v, input int idx);
        @(negedge clock);
        sample = 1'b1; inbit = v.b; stuffr = v.st; stferror = v.se;
        @(negedge clock);
        sample = 1'b0;
        chk($sformatf("actvrstf[%0d]", idx), int'(actvrstf), 1);
        chk($sformatf("actvrdct[%0d]", idx), int'(actvrdct), int'(v.e_dct));
        @(negedge clock);
        if (v.ab) abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk($sformatf("bitvalid[%0d]", idx), int'(bitvalid), int'(v.e_bv));
        if (v.e_bv) chk($sformatf("rxbit[%0d]", idx), int'(rxbit), int'(v.b));
        chk($sformatf("stferr[%0d]", idx), int'(stferr), int'(v.e_sf));
        chk($sformatf("frame_done[%0d]", idx), int'(frame_done), int'(v.e_done));
        chk($sformatf("bitpos[%0d]", idx), int'(bitpos), int'(v.e_pos));
        last_resetdst = resetdst;
        last_busy     = busy;
    endtask

    task automatic run_vectors();
        for (int i = 0; i < vq.size(); i++) do_sample(vq[i], i);
    endtask

    // Start and sample together: the sample must be ignored
    task automatic start_frame(input string name);
        @(negedge clock);
        start = 1'b1; sample = 1'b1;
        @(negedge clock);
        start = 1'b0; sample = 1'b0;
        chk({name, "_start_resetdst"}, int'(resetdst), 0);
        chk({name, "_start_busy"}, int'(busy), 1);
        chk({name, "_start_actvrstf"}, int'(actvrstf), 0);
        chk({name, "_start_bitpos"}, int'(bitpos), 0);
        chk({name, "_start_fields"}, int'({ide, rtr, dlc}), 0);
        @(negedge clock);
        chk({name, "_start_resetdst_rel"}, int'(resetdst), 1);
        chk({name, "_start_actvrstf_idle"}, int'(actvrstf), 0);
    endtask

    task automatic end_check(input string name);
        chk({name, "_flush_resetdst"}, int'(last_resetdst), 0);
        chk({name, "_flush_busy"}, int'(last_busy), 1);
        @(negedge clock);
        chk({name, "_idle_busy"}, int'(busy), 0);
        chk({name, "_idle_resetdst"}, int'(resetdst), 1);
        chk({name, "_idle_pulses"}, int'({stferr, frame_done, bitvalid}), 0);
    endtask

    task automatic check_fields(input string name, input int e_pos, input logic e_ide,
                                input logic e_rtr, input logic [3:0] e_dlc);
        chk({name, "_bitpos"}, int'(bitpos), e_pos);
        chk({name, "_ide"}, int'(ide), int'(e_ide));
        chk({name, "_rtr"}, int'(rtr), int'(e_rtr));
        chk({name, "_dlc"}, int'(dlc), int'(e_dlc));
    endtask

    initial begin
        reset = 1'b1; sample = 1'b0; start = 1'b0; abort = 1'b0;
        stuffr = 1'b0; stferror = 1'b0; inbit = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_actv", int'({actvrstf, actvrdct}), 0);
        chk("rst_resetdst", int'(resetdst), 1);
        chk("rst_bit", int'({rxbit, bitvalid}), 0);
        chk("rst_bitpos", int'(bitpos), 0);
        chk("rst_fields", int'({ide, rtr, dlc}), 0);
        chk("rst_status", int'({busy, frame_done, stferr}), 0);
        reset = 1'b1;

        // Standard data frame, DLC=0
        start_frame("std0");
        build_frame(1'b0, 1'b0, 4'd0, 11'h555, -1, 1'b0);
        run_vectors();
        check_fields("std0", 34, 1'b0, 1'b0, 4'd0);
        end_check("std0");

        // Stuff bit after five dominant ID bits
        start_frame("stf");
        build_frame(1'b0, 1'b0, 4'd0, 11'h01F, 6, 1'b0);
        run_vectors();
        check_fields("stf", 34, 1'b0, 1'b0, 4'd0);
        end_check("stf");

        // Stuff error at k=20
        start_frame("serr");
        build_frame(1'b0, 1'b0, 4'd1, 11'h2A5, -1, 1'b0);
        while (vq.size() > 20) void'(vq.pop_back());
        vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd20));
        run_vectors();
        end_check("serr");

        // Extended remote frame, DLC=15 gives no data
        start_frame("extr");
        build_frame(1'b1, 1'b1, 4'd15, 11'h123, -1, 1'b0);
        run_vectors();
        check_fields("extr", 54, 1'b1, 1'b1, 4'd15);
        end_check("extr");

        // Extended data frame, DLC=15 clamps to 8 bytes
        start_frame("extd");
        build_frame(1'b1, 1'b0, 4'd15, 11'h123, -1, 1'b0);
        run_vectors();
        check_fields("extd", 118, 1'b1, 1'b0, 4'd15);
        end_check("extd");

        // Stuff bit on the first TAIL sample
        start_frame("tail");
        build_frame(1'b0, 1'b0, 4'd0, 11'h555, -1, 1'b1);
        run_vectors();
        check_fields("tail", 34, 1'b0, 1'b0, 4'd0);
        end_check("tail");

        // Standard data frame, DLC=2
        start_frame("std2");
        build_frame(1'b0, 1'b0, 4'd2, 11'h6B1, -1, 1'b0);
        run_vectors();
        check_fields("std2", 50, 1'b0, 1'b0, 4'd2);
        end_check("std2");

        // Abort in the evaluation cycle of k=5, then a clean restart
        start_frame("abrt");
        build_frame(1'b0, 1'b0, 4'd2, 11'h0F0, -1, 1'b0);
        while (vq.size() > 5) void'(vq.pop_back());
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd5));
        run_vectors();
        end_check("abrt");

        start_frame("rest");
        build_frame(1'b0, 1'b1, 4'd3, 11'h3C3, -1, 1'b0);
        run_vectors();
        check_fields("rest", 34, 1'b0, 1'b1, 4'd3);
        end_check("rest");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
